// File: rtl/rf_write_ctrl_if.sv
// Write-back request handshake from the datapath into rf_write_ctrl.
interface rf_write_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rf_write_ctrl.sv
// Register-file write-port driver: clears r1..rN after reset, then drains a small write-back FIFO.
// Optional pending-write forwarding enabled by defining RF_WRITE_FWD_EN.
module rf_write_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  rf_write_ctrl_if.slave                req,
  input  logic                          wb_hold,
  input  logic                          flush,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  input  logic [ADDR_WIDTH-1:0]         fwd_addr,
  output logic                          fwd_hit,
  output logic [DATA_WIDTH-1:0]         fwd_data,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   pending_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count;
  logic                  empty, full, push, pop;

  assign empty       = (count == '0);
  assign full        = (count == (PW+1)'(FIFO_DEPTH));
  assign pending_cnt = count;

  always_comb begin
    req.req_ready = 1'b0;
    rf_wen        = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    init_done     = 1'b0;
    if (state == INIT) begin
      rf_wen   = 1'b1;
      rf_waddr = init_cnt;
    end else begin
      init_done     = 1'b1;
      req.req_ready = !full && !flush;
      rf_wen        = !empty && !wb_hold;
      if (!empty) begin
        rf_waddr = q_addr[rd_ptr];
        rf_wdata = q_data[rd_ptr];
      end
    end
  end

  // Writes to r0 are accepted but never occupy a slot.
  assign push = req.req_valid && req.req_ready && (req.req_addr != '0);
  assign pop  = (state == RUN) && rf_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= ADDR_WIDTH'(1);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + ADDR_WIDTH'(1);
      if (init_cnt == '1) state <= RUN;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == RUN && !flush && push) begin
      q_addr[wr_ptr] <= req.req_addr;
      q_data[wr_ptr] <= req.req_data;
    end
  end

`ifdef RF_WRITE_FWD_EN
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (fwd_addr != '0) &&
          (q_addr[rd_ptr + PW'(i)] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[rd_ptr + PW'(i)];
      end
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Randomized bench for rf_write_ctrl against a queue-based reference model.
module tb_rf_write_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, wb_hold, flush;
  logic          rf_wen, fwd_hit, init_done;
  logic [AW-1:0] rf_waddr, fwd_addr;
  logic [DW-1:0] rf_wdata, fwd_data;
  logic [2:0]    pending_cnt;

  rf_write_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rif ();

  rf_write_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(rif.slave), .wb_hold(wb_hold), .flush(flush),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .init_done(init_done), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [DW-1:0] data; } entry_t;

  entry_t q[$];
  bit     known   = 0;
  bit     in_init = 1;
  int     init_addr = 1;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model at the edge.
  task automatic cycle(input bit v, input int a, input logic [DW-1:0] d, input bit hold,
                       input bit fl, input bit r, input int fa);
    bit            e_wen, e_rdy, e_hit;
    int            e_waddr;
    logic [DW-1:0] e_wdata, e_fdata;
    rif.req_valid = v;
    rif.req_addr  = AW'(a);
    rif.req_data  = d;
    wb_hold = hold;
    flush   = fl;
    rst     = r;
    fwd_addr = AW'(fa);
    #1;
    if (in_init) begin
      e_wen = 1; e_waddr = init_addr; e_wdata = '0; e_rdy = 0;
      e_hit = 0; e_fdata = '0;
    end else begin
      e_rdy   = (q.size() < DEPTH) && !fl;
      e_wen   = (q.size() > 0) && !hold;
      e_waddr = (q.size() > 0) ? q[0].addr : 0;
      e_wdata = (q.size() > 0) ? q[0].data : '0;
      e_hit = 0; e_fdata = '0;
`ifdef RF_WRITE_FWD_EN
      if (fa != 0)
        foreach (q[i]) if (q[i].addr == fa) begin e_hit = 1; e_fdata = q[i].data; end
`endif
    end
    if (known) begin
      check("rf_wen",      32'(rf_wen),      32'(e_wen));
      check("rf_waddr",    32'(rf_waddr),    32'(e_waddr));
      check("rf_wdata",    rf_wdata,         e_wdata);
      check("req_ready",   32'(rif.req_ready), 32'(e_rdy));
      check("init_done",   32'(init_done),   32'(!in_init));
      check("fwd_hit",     32'(fwd_hit),     32'(e_hit));
      check("fwd_data",    fwd_data,         e_fdata);
      check("pending_cnt", 32'(pending_cnt), 32'(q.size()));
    end
    @(posedge clk);
    if (r) begin
      known = 1; in_init = 1; init_addr = 1; q.delete();
    end else if (in_init) begin
      if (init_addr == 31) in_init = 0;
      else init_addr++;
    end else if (fl) begin
      q.delete();
    end else begin
      if (e_wen) void'(q.pop_front());
      if (v && e_rdy && a != 0) q.push_back('{addr: a, data: d});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle(0, 0, '0, 0, 0, 1, 0);
    // Clear sequence, with requests and flush presented and ignored.
    for (int i = 0; i < 31; i++) cycle(i % 3 == 0, 7, 32'hA5A5_0000 + i, 0, i % 5 == 0, 0, 7);
    idle(1);
    cycle(1, 3, 32'hDEADBEEF, 0, 0, 0, 3);
    idle(2);
    cycle(1, 0, 32'h12345678, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) cycle(1, 8 + i, 32'h100 + i, 1, 0, 0, 9);
    idle(5);
    cycle(1, 5, 32'd1, 1, 0, 0, 5);
    cycle(1, 5, 32'd2, 1, 0, 0, 5);
    cycle(0, 0, '0, 1, 0, 0, 5);
    cycle(0, 0, '0, 1, 0, 0, 0);
    cycle(0, 0, '0, 1, 0, 0, 6);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1, 20 + i, 32'h200 + i, 1, 0, 0, 21);
    cycle(1, 25, 32'h250, 0, 1, 0, 21);
    idle(2);
    for (int i = 0; i < 3; i++) cycle(1, 10 + i, 32'h300 + i, 1, 0, 0, 0);
    cycle(0, 0, '0, 0, 0, 0, 0);
    cycle(0, 0, '0, 0, 0, 1, 0);
    idle(33);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            $urandom_range(0, 299) == 0, $urandom_range(0, 7));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
